// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU launch controller slice.
package npu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RUN, WB} npu_state_e;

  localparam int          TRIG_REG_DEF    = 13;
  localparam int          RES_REG_DEF     = 14;
  localparam logic [31:0] NPU_TIMEOUT_VAL = 32'hFFFF_FFFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/npu_wport_mux.sv
// Register-file write-port arbiter: a pending NPU result only takes the port when the pipeline is not writing.
module npu_wport_mux #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RES_REG = 14
) (
  input  logic              wb_pend,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_wr,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] res_wd,
  output logic              grant,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wd
);
  always_comb begin
    grant = wb_pend && !wb_regwrite;
    rf_we = wb_regwrite;
    rf_wr = wb_wr;
    rf_wd = wb_wd;
    if (grant) begin
      rf_we = 1'b1;
      rf_wr = ADDR_W'(RES_REG);
      rf_wd = res_wd;
    end
  end
endmodule

// File: rtl/npu_launch_ctrl.sv
// NPU launch sequencer: a nonzero write to TRIG_REG starts a job, the result lands in RES_REG.
// Optional NPU_PERF_CNT_EN adds npu_cycles, the REQ-to-WB-exit length of the last finished job.
module npu_launch_ctrl import npu_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TRIG_REG = TRIG_REG_DEF,
  parameter int RES_REG  = RES_REG_DEF,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_wr,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              npu_req,
  output logic [DATA_W-1:0] npu_arg,
  input  logic              npu_ack,
  input  logic              npu_done,
  input  logic [DATA_W-1:0] npu_result,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              npu_stall,
  output logic              npu_err,
  output logic [7:0]        drop_cnt
`ifdef NPU_PERF_CNT_EN
  ,
  output logic [15:0]       npu_cycles
`endif
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  npu_state_e        state, state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] res_buf;
  logic              trig, tmo, grant, wb_pend;

  assign trig = wb_regwrite && (wb_wr == ADDR_W'(TRIG_REG)) && (wb_wd != '0);
  assign tmo  = (timer == TMR_W'(TIMEOUT));

  always_ff @(posedge clk_50) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trig)             state_nxt = REQ;
      REQ:     if (npu_ack)          state_nxt = RUN;
      RUN:     if (npu_done || tmo)  state_nxt = WB;
      WB:      if (grant)            state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    npu_req = (state == REQ);
    wb_pend = (state == WB);
  end

  // Stall flop tracks next state so it equals (state != IDLE) without a comb path from wb_*.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      npu_stall <= 1'b0;
      npu_arg   <= '0;
      res_buf   <= '0;
      timer     <= '0;
      npu_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      npu_stall <= (state_nxt != IDLE);
      if (trig && state == IDLE) npu_arg  <= wb_wd;
      if (trig && state != IDLE) drop_cnt <= sat_inc8(drop_cnt);
      case (state)
        REQ: timer <= '0;
        RUN: begin
          timer <= timer + TMR_W'(1);
          if (npu_done) res_buf <= npu_result;
          else if (tmo) begin
            res_buf <= '1;
            npu_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NPU_PERF_CNT_EN
  logic [15:0] cyc_cnt;

  // Preloaded to 1 in IDLE so the first REQ cycle already counts.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      cyc_cnt    <= '0;
      npu_cycles <= '0;
    end else begin
      cyc_cnt <= (state == IDLE) ? 16'd1 : sat_inc16(cyc_cnt);
      if (grant) npu_cycles <= cyc_cnt;
    end
  end
`endif

  npu_wport_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RES_REG(RES_REG)) u_wport_mux (
    .wb_pend     (wb_pend),
    .wb_regwrite (wb_regwrite),
    .wb_wr       (wb_wr),
    .wb_wd       (wb_wd),
    .res_wd      (res_buf),
    .grant       (grant),
    .rf_we       (rf_we),
    .rf_wr       (rf_wr),
    .rf_wd       (rf_wd)
  );
endmodule

// File: tb/tb_npu_launch_ctrl.sv
// Bench for npu_launch_ctrl: directed table, corner sequences and random traffic against a job-level model.
module tb_npu_launch_ctrl;
  localparam int TIMEOUT = 1023;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        wb_regwrite;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        npu_req;
  logic [31:0] npu_arg;
  logic        npu_ack;
  logic        npu_done;
  logic [31:0] npu_result;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        npu_stall;
  logic        npu_err;
  logic [7:0]  drop_cnt;

  always #5 clk_50 = ~clk_50;

  npu_launch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_50(clk_50), .rst(rst),
    .wb_regwrite(wb_regwrite), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .npu_req(npu_req), .npu_arg(npu_arg), .npu_ack(npu_ack),
    .npu_done(npu_done), .npu_result(npu_result),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .npu_stall(npu_stall), .npu_err(npu_err), .drop_cnt(drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Job-level model: a job is waiting for ack, running, or holding a result for the port.
  bit          m_waiting, m_running, m_holding, m_err;
  int          m_run_cycles, m_drop;
  logic [31:0] m_result, m_arg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_running = 0; m_holding = 0; m_err = 0;
    m_run_cycles = 0; m_drop = 0; m_result = '0; m_arg = '0;
  endtask

  task automatic check_model();
    bit busy, takes_port;
    busy       = m_waiting || m_running || m_holding;
    takes_port = m_holding && !wb_regwrite;
    chk("npu_req",   npu_req,   m_waiting);
    chk("npu_stall", npu_stall, busy);
    chk("npu_arg",   npu_arg,   m_arg);
    chk("npu_err",   npu_err,   m_err);
    chk("drop_cnt",  drop_cnt,  m_drop);
    chk("rf_we",     rf_we,     takes_port ? 1'b1 : wb_regwrite);
    chk("rf_wr",     rf_wr,     takes_port ? 5'd14 : wb_wr);
    chk("rf_wd",     rf_wd,     takes_port ? m_result : wb_wd);
  endtask

  task automatic step_model();
    bit busy, trig, was_waiting, was_running, was_holding;
    busy        = m_waiting || m_running || m_holding;
    trig        = wb_regwrite && wb_wr == 5'd13 && wb_wd != 0;
    was_waiting = m_waiting;
    was_running = m_running;
    was_holding = m_holding;
    if (was_waiting && npu_ack) begin
      m_waiting = 0; m_running = 1; m_run_cycles = 0;
    end
    if (was_running) begin
      if (npu_done) begin
        m_result = npu_result; m_running = 0; m_holding = 1;
      end else if (m_run_cycles == TIMEOUT) begin
        m_result = 32'hFFFF_FFFF; m_err = 1; m_running = 0; m_holding = 1;
      end else m_run_cycles++;
    end
    if (was_holding && !wb_regwrite) m_holding = 0;
    if (trig) begin
      if (!busy) begin m_arg = wb_wd; m_waiting = 1; end
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic drive(input bit regw, input logic [4:0] wr, input logic [31:0] wd,
                       input bit ack, input bit done, input logic [31:0] res);
    wb_regwrite = regw; wb_wr = wr; wb_wd = wd;
    npu_ack = ack; npu_done = done; npu_result = res;
  endtask

  // Called at negedge: apply inputs, check just before the rising edge.
  task automatic cyc_a(input bit regw, input logic [4:0] wr, input logic [31:0] wd,
                       input bit ack, input bit done, input logic [31:0] res);
    drive(regw, wr, wd, ack, done, res);
    #4;
    check_model();
  endtask

  task automatic cyc_b();
    @(posedge clk_50);
    step_model();
    @(negedge clk_50);
  endtask

  task automatic cyc(input bit regw, input logic [4:0] wr, input logic [31:0] wd,
                     input bit ack, input bit done, input logic [31:0] res);
    cyc_a(regw, wr, wd, ack, done, res);
    cyc_b();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic do_reset();
    drive(0, 5'd0, 32'd0, 0, 0, 32'd0);
    rst = 1'b1;
    @(posedge clk_50);
    model_reset();
    @(negedge clk_50);
    rst = 1'b0;
  endtask

  typedef struct {
    bit regw; logic [4:0] wr; logic [31:0] wd; bit ack; bit done; logic [31:0] res;
    bit e_req; bit e_stall; bit e_we; logic [4:0] e_wr; logic [31:0] e_wd;
  } vec_t;

  vec_t tv[9];

  initial begin
    int k;
    bit found;

    tv[0] = '{1, 5'd13, 32'h5, 0, 0, 32'h0,    0, 0, 1, 5'd13, 32'h5};
    tv[1] = '{0, 5'd0,  32'h0, 0, 0, 32'h0,    1, 1, 0, 5'd0,  32'h0};
    tv[2] = '{0, 5'd0,  32'h0, 1, 0, 32'h0,    1, 1, 0, 5'd0,  32'h0};
    tv[3] = '{0, 5'd0,  32'h0, 0, 0, 32'h0,    0, 1, 0, 5'd0,  32'h0};
    tv[4] = tv[3];
    tv[5] = tv[3];
    tv[6] = '{0, 5'd0,  32'h0, 0, 1, 32'hABCD, 0, 1, 0, 5'd0,  32'h0};
    tv[7] = '{0, 5'd0,  32'h0, 0, 0, 32'h0,    0, 1, 1, 5'd14, 32'hABCD};
    tv[8] = '{0, 5'd0,  32'h0, 0, 0, 32'h0,    0, 0, 0, 5'd0,  32'h0};

    rst = 1'b1;
    drive(0, 5'd0, 32'd0, 0, 0, 32'd0);
    model_reset();
    @(negedge clk_50);
    do_reset();
    chk("reset_req",   npu_req,   0);
    chk("reset_stall", npu_stall, 0);
    chk("reset_err",   npu_err,   0);
    chk("reset_drop",  drop_cnt,  0);
    chk("reset_arg",   npu_arg,   0);

    // Basic job with the documented timing.
    for (int i = 0; i < 9; i++) begin
      cyc_a(tv[i].regw, tv[i].wr, tv[i].wd, tv[i].ack, tv[i].done, tv[i].res);
      chk($sformatf("t1_req[%0d]", i),   npu_req,   tv[i].e_req);
      chk($sformatf("t1_stall[%0d]", i), npu_stall, tv[i].e_stall);
      chk($sformatf("t1_we[%0d]", i),    rf_we,     tv[i].e_we);
      if (tv[i].e_we) begin
        chk($sformatf("t1_wr[%0d]", i), rf_wr, tv[i].e_wr);
        chk($sformatf("t1_wd[%0d]", i), rf_wd, tv[i].e_wd);
      end
      cyc_b();
    end
    chk("t1_arg", npu_arg, 32'h5);

    // Zero write to the trigger register does nothing.
    cyc(1, 5'd13, 32'h0, 0, 0, 32'h0);
    idle(2);
    chk("t2_req", npu_req, 0);
    chk("t2_stall", npu_stall, 0);
    chk("t2_drop", drop_cnt, 0);

    // Result write deferred behind three pipeline writes.
    cyc(1, 5'd13, 32'h77, 0, 0, 32'h0);
    idle(1);
    cyc(0, 5'd0, 32'h0, 1, 0, 32'h0);
    cyc(0, 5'd0, 32'h0, 0, 1, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      cyc_a(1, 5'd3, 32'hA0 + i, 0, 0, 32'h0);
      chk("t3_pipe_wr", rf_wr, 5'd3);
      chk("t3_pipe_wd", rf_wd, 32'hA0 + i);
      cyc_b();
    end
    cyc_a(0, 5'd0, 32'h0, 0, 0, 32'h0);
    chk("t3_npu_we", rf_we, 1);
    chk("t3_npu_wr", rf_wr, 5'd14);
    chk("t3_npu_wd", rf_wd, 32'h1234);
    cyc_b();
    idle(1);

    // Timeout after ack with no done.
    cyc(1, 5'd13, 32'h42, 0, 0, 32'h0);
    cyc(0, 5'd0, 32'h0, 1, 0, 32'h0);
    found = 0;
    for (k = 0; k < TIMEOUT + 20; k++) begin
      cyc_a(0, 5'd0, 32'h0, 0, 0, 32'h0);
      if (rf_we && rf_wr == 5'd14) begin
        found = 1;
        chk("t4_wd", rf_wd, 32'hFFFF_FFFF);
        chk("t4_latency", k, TIMEOUT + 1);
        cyc_b();
        break;
      end
      cyc_b();
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL t4_timeout_write: got none expected x14 write within %0d cycles", TIMEOUT + 20);
    end
    chk("t4_err", npu_err, 1);
    cyc(1, 5'd13, 32'h9, 0, 0, 32'h0);
    cyc(0, 5'd0, 32'h0, 1, 0, 32'h0);
    cyc(0, 5'd0, 32'h0, 0, 1, 32'h55);
    idle(2);
    chk("t4_err_sticky", npu_err, 1);

    // Triggers while busy are dropped, count saturates.
    do_reset();
    cyc(1, 5'd13, 32'h1, 0, 0, 32'h0);
    cyc(0, 5'd0, 32'h0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 5'd13, 32'h9, 0, 0, 32'h0);
    cyc_a(0, 5'd0, 32'h0, 0, 0, 32'h0);
    chk("t5_drop3", drop_cnt, 3);
    chk("t5_arg", npu_arg, 32'h1);
    cyc_b();
    for (int i = 0; i < 300; i++) cyc(1, 5'd13, 32'h9, 0, 0, 32'h0);
    cyc_a(0, 5'd0, 32'h0, 0, 0, 32'h0);
    chk("t5_drop_sat", drop_cnt, 255);
    chk("t5_still_busy", npu_stall, 1);
    cyc_b();
    cyc(0, 5'd0, 32'h0, 0, 1, 32'h66);
    idle(2);

    // Reset mid-run abandons the job; a late done is ignored.
    do_reset();
    cyc(1, 5'd13, 32'h3, 0, 0, 32'h0);
    cyc(0, 5'd0, 32'h0, 1, 0, 32'h0);
    idle(2);
    do_reset();
    chk("t6_stall", npu_stall, 0);
    chk("t6_req", npu_req, 0);
    chk("t6_err", npu_err, 0);
    cyc(0, 5'd0, 32'h0, 0, 1, 32'hDEAD);
    cyc_a(0, 5'd0, 32'h0, 0, 0, 32'h0);
    chk("t6_no_write", rf_we, 0);
    chk("t6_idle", npu_stall, 0);
    cyc_b();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  wr;
      logic [31:0] wd;
      case ($urandom_range(0, 3))
        0, 1:    wr = 5'd13;
        2:       wr = 5'd14;
        default: wr = 5'($urandom_range(0, 31));
      endcase
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 3) == 0, wr, wd, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
